// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Memory-side request/response bus between the LSU controller and data memory.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Lane placement, byte enables, load extension and access legality checks.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  lane_i,
  input  logic        is_load_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [31:0] rsh;

  always_comb begin
    // Size lives in func3[1:0], so alignment is judged even for illegal encodings.
    misaligned_o = ((func3_i[1:0] == 2'b01) && lane_i[0]) ||
                   ((func3_i[1:0] == 2'b10) && (lane_i != 2'b00));

    if (is_load_i) begin
      illegal_o = !((func3_i == F3_B) || (func3_i == F3_H) || (func3_i == F3_W) ||
                    (func3_i == F3_BU) || (func3_i == F3_HU));
    end else begin
      illegal_o = !((func3_i == F3_B) || (func3_i == F3_H) || (func3_i == F3_W));
    end

    case (func3_i[1:0])
      2'b00: begin
        wdata_o = {4{wdata_i[7:0]}};
        be_o    = 4'b0001 << lane_i;
      end
      2'b01: begin
        wdata_o = {2{wdata_i[15:0]}};
        be_o    = 4'b0011 << lane_i;
      end
      default: begin
        wdata_o = wdata_i;
        be_o    = 4'b1111;
      end
    endcase

    rsh = rdata_i >> {lane_i, 3'b000};
    case (func3_i)
      F3_B:    rdata_o = {{24{rsh[7]}}, rsh[7:0]};
      F3_H:    rdata_o = {{16{rsh[15]}}, rsh[15:0]};
      F3_BU:   rdata_o = {24'd0, rsh[7:0]};
      F3_HU:   rdata_o = {16'd0, rsh[15:0]};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one memory access in flight, with alignment,
// illegal-size and ack-timeout faults.
//
//   state  | meaning
//   IDLE   | waiting for cs=0; decodes and checks the access
//   BUSY   | mem_req held with latched address/data until mem_ack or timeout
//   DONE   | one cycle; load_valid strobe for loads
//   ERR    | one cycle; fault strobe with fault_code
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              fault,
  output logic [1:0]        fault_code,
  lsu_ctrl_if.master        mem
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        func3_q, func3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_load_q, is_load_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        code_q, code_d;
  logic [31:0]       load_data_q, load_data_d;

  logic        idle, busy, op_valid;
  logic [2:0]  al_func3;
  logic [1:0]  al_lane;
  logic        al_is_load;
  logic [31:0] al_wdata_in, al_wdata, al_rdata;
  logic [3:0]  al_be;
  logic        al_misaligned, al_illegal;

  assign idle     = (state_q == S_IDLE);
  assign busy     = (state_q == S_BUSY);
  assign op_valid = rd_en || !wr_en;

  // One aligner serves both phases: live decoder inputs in IDLE, latched access otherwise.
  assign al_func3    = idle ? func3     : func3_q;
  assign al_lane     = idle ? addr[1:0] : addr_q[1:0];
  assign al_is_load  = idle ? rd_en     : is_load_q;
  assign al_wdata_in = idle ? wdata     : wdata_q;

  lsu_align u_align (
    .func3_i      (al_func3),
    .lane_i       (al_lane),
    .is_load_i    (al_is_load),
    .wdata_i      (al_wdata_in),
    .rdata_i      (mem.mem_rdata),
    .wdata_o      (al_wdata),
    .be_o         (al_be),
    .rdata_o      (al_rdata),
    .misaligned_o (al_misaligned),
    .illegal_o    (al_illegal)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    func3_d     = func3_q;
    wdata_d     = wdata_q;
    is_load_d   = is_load_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    load_data_d = load_data_q;

    case (state_q)
      S_IDLE: begin
        if (!cs) begin
          if (!op_valid) begin
            state_d = S_ERR;
            code_d  = FC_ILLEGAL;
          end else if (al_misaligned) begin
            state_d = S_ERR;
            code_d  = FC_MISALIGN;
          end else if (al_illegal) begin
            state_d = S_ERR;
            code_d  = FC_ILLEGAL;
          end else begin
            state_d   = S_BUSY;
            addr_d    = addr;
            func3_d   = func3;
            wdata_d   = wdata;
            is_load_d = rd_en;
            cnt_d     = '0;
          end
        end
      end
      S_BUSY: begin
        // An ack on the final allowed cycle still completes the access.
        if (mem.mem_ack) begin
          state_d = S_DONE;
          if (is_load_q) load_data_d = al_rdata;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
          code_d  = FC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      func3_q     <= '0;
      wdata_q     <= '0;
      is_load_q   <= 1'b0;
      cnt_q       <= '0;
      code_q      <= FC_NONE;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      func3_q     <= func3_d;
      wdata_q     <= wdata_d;
      is_load_q   <= is_load_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      load_data_q <= load_data_d;
    end
  end

  assign stall      = (idle && !cs) || busy;
  assign load_data  = load_data_q;
  assign load_valid = (state_q == S_DONE) && is_load_q;
  assign fault      = (state_q == S_ERR);
  assign fault_code = (state_q == S_ERR) ? code_q : FC_NONE;

  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy && !is_load_q;
  assign mem.mem_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem.mem_wdata = busy ? al_wdata : 32'd0;
  assign mem.mem_be    = busy ? al_be : 4'b0000;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table with a scoreboard queue plus reset corner cases.
module tb_lsu_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, rd_en, wr_en;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_code;

  lsu_ctrl_if #(.ADDR_W(32)) mif ();

  lsu_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .func3      (func3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .fault      (fault),
    .fault_code (fault_code),
    .mem        (mif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic [1:0]  dcode;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] ldv;
  } vec_t;

  typedef struct {
    logic        flt;
    logic [1:0]  code;
    logic        lv;
    logic [31:0] ldata;
    int          stalls;
    int          reqs;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_ld = 32'd0;
  exp_t        sb[$];
  vec_t        vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   stalls, reqs;
    bit   done;
    logic tmo;
    if (v.dcode != 2'b00) begin
      e = '{1'b1, v.dcode, 1'b0, last_ld, 1, 0};
    end else begin
      tmo      = (v.dly + 1) > TO;
      e.reqs   = tmo ? TO : v.dly + 1;
      e.flt    = tmo;
      e.code   = tmo ? 2'b10 : 2'b00;
      e.lv     = v.ld && !tmo;
      e.ldata  = e.lv ? v.ldv : last_ld;
      e.stalls = 1 + e.reqs;
    end
    last_ld = e.ldata;
    sb.push_back(e);

    @(negedge clk);
    cs = 1'b0; rd_en = v.ld; wr_en = !v.st; func3 = v.f3; addr = v.a; wdata = v.wd;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h5A5A5A5A;
    stalls = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_sb_empty", idx), 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d_fault", idx), 32'(fault), 32'(e.flt));
          chk($sformatf("v%0d_code", idx), 32'(fault_code), 32'(e.code));
          chk($sformatf("v%0d_lvalid", idx), 32'(load_valid), 32'(e.lv));
          chk($sformatf("v%0d_ldata", idx), load_data, e.ldata);
          chk($sformatf("v%0d_stalls", idx), 32'(stalls), 32'(e.stalls));
          chk($sformatf("v%0d_reqs", idx), 32'(reqs), 32'(e.reqs));
          chk($sformatf("v%0d_req_end", idx), 32'(mif.mem_req), 32'd0);
        end
      end else begin
        stalls++;
        if (mif.mem_req) begin
          reqs++;
          chk($sformatf("v%0d_maddr", idx), mif.mem_addr, {v.a[31:2], 2'b00});
          chk($sformatf("v%0d_be", idx), 32'(mif.mem_be), 32'(v.be));
          chk($sformatf("v%0d_we", idx), 32'(mif.mem_we), 32'(v.st));
          if (v.st) chk($sformatf("v%0d_mwdata", idx), mif.mem_wdata, v.mwd);
          mif.mem_ack   = (reqs == v.dly + 1);
          mif.mem_rdata = mif.mem_ack ? v.rd : 32'h5A5A5A5A;
        end else begin
          mif.mem_ack = 1'b0;
        end
        @(negedge clk);
      end
    end
    if (!done) chk($sformatf("v%0d_complete_timeout", idx), 32'd0, 32'd1);
    cs = 1'b1; mif.mem_ack = 1'b0;
    @(negedge clk); #1;
    chk($sformatf("v%0d_lvalid_once", idx), 32'(load_valid), 32'd0);
    chk($sformatf("v%0d_fault_once", idx), 32'(fault), 32'd0);
    chk($sformatf("v%0d_idle_stall", idx), 32'(stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    //         ld    st    f3    addr          wdata         rdata        dly dcode  be       mwdata        load value
    vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 3,  2'b00, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h103, 32'h0,        32'h80123456, 0,  2'b00, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h103, 32'h0,        32'h80123456, 1,  2'b00, 4'b1000, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b0, 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0,        1,  2'b00, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        0,  2'b01, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0,        99, 2'b00, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 3'd2, 32'h304, 32'h11223344, 32'h0,        14, 2'b00, 4'b1111, 32'h11223344, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 2,  2'b00, 4'b1100, 32'h0,        32'hFFFF8001};
    vecs[8]  = '{1'b1, 1'b0, 3'd5, 32'h100, 32'h0,        32'h1234F00F, 0,  2'b00, 4'b0011, 32'h0,        32'h0000F00F};
    vecs[9]  = '{1'b0, 1'b1, 3'd0, 32'h101, 32'h000000A5, 32'h0,        0,  2'b00, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'd4, 32'h100, 32'h0,        32'h0,        0,  2'b11, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'd1, 32'h201, 32'h0,        32'h0,        0,  2'b01, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 1'b1, 3'd5, 32'h201, 32'h0,        32'h0,        0,  2'b01, 4'b0000, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'd2, 32'h10C, 32'h0,        32'h01020304, 0,  2'b00, 4'b1111, 32'h0,        32'h01020304};

    rst_n = 1'b0; cs = 1'b1; rd_en = 1'b0; wr_en = 1'b1; func3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_we", 32'(mif.mem_we), 32'd0);
    chk("rst_be", 32'(mif.mem_be), 32'd0);
    chk("rst_lvalid", 32'(load_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    rst_n = 1'b1;

    // Ack while idle must not produce any completion.
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk); #1;
      chk("idle_ack_lvalid", 32'(load_valid), 32'd0);
      chk("idle_ack_req", 32'(mif.mem_req), 32'd0);
      chk("idle_ack_ldata", load_data, 32'd0);
    end
    mif.mem_ack = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a load, then a stray ack.
    @(negedge clk);
    cs = 1'b0; rd_en = 1'b1; wr_en = 1'b1; func3 = 3'd2; addr = 32'h400;
    @(negedge clk); #1;
    chk("rb_busy_req", 32'(mif.mem_req), 32'd1);
    rst_n = 1'b0; cs = 1'b1;
    @(negedge clk); #1;
    chk("rb_req_drop", 32'(mif.mem_req), 32'd0);
    chk("rb_stall", 32'(stall), 32'd0);
    rst_n = 1'b1; mif.mem_ack = 1'b1; mif.mem_rdata = 32'h12345678;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rb_lvalid", 32'(load_valid), 32'd0);
      chk("rb_fault", 32'(fault), 32'd0);
      chk("rb_req", 32'(mif.mem_req), 32'd0);
    end
    chk("rb_ldata", load_data, 32'd0);
    mif.mem_ack = 1'b0;
    last_ld = 32'd0;

    run_vec(14, vecs[1]);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
